// File: rtl/tt_alu_seq_if.sv
// Operation/result bundle for tt_alu_seq: an operation side (in_*) and a result side (out_*).
// Both sides transfer on a cycle where valid && ready are high; the producer holds its payload until then.
interface tt_alu_seq_if #(
   parameter int W = 4
);
   logic           in_valid;
   logic           in_ready;
   logic [W-1:0]   in_a;
   logic [W-1:0]   in_b;
   logic [2:0]     in_op;
   logic           out_valid;
   logic           out_ready;
   logic [2*W-1:0] out_result;
   logic           out_zero;
   logic           out_borrow;
   logic           out_err;

   modport master (
      output in_valid, in_a, in_b, in_op, out_ready,
      input  in_ready, out_valid, out_result, out_zero, out_borrow, out_err
   );

   modport slave (
      input  in_valid, in_a, in_b, in_op, out_ready,
      output in_ready, out_valid, out_result, out_zero, out_borrow, out_err
   );
endinterface

// File: rtl/tt_alu_seq.sv
// Multi-cycle ALU: single-cycle add/sub/logic, iterative shift-add multiply and restoring divide.
// One operation in flight; result and flags are registered and held in DONE until taken.
module tt_alu_seq #(
   parameter int W = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   tt_alu_seq_if.slave bus,
   output logic [1:0]  state_o
);
   localparam int CW = $clog2(W);

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_MUL = 3'b010;
   localparam logic [2:0] OP_DIV = 3'b011;
   localparam logic [2:0] OP_AND = 3'b100;
   localparam logic [2:0] OP_OR  = 3'b101;
   localparam logic [2:0] OP_XOR = 3'b110;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [2*W-1:0] work_q, work_d;
   logic [W-1:0]   b_q, b_d;
   logic           div_q, div_d;
   logic [2*W-1:0] res_q, res_d;
   logic           zero_q, zero_d;
   logic           borrow_q, borrow_d;
   logic           err_q, err_d;

   logic [2*W-1:0] imm_res;
   logic           imm_borrow;
   logic           imm_err;
   logic [W:0]     mul_sum;
   logic [2*W-1:0] mul_next;
   logic [W:0]     div_shift;
   logic           div_ge;
   logic [W-1:0]   div_rem;
   logic [2*W-1:0] div_next;
   logic [2*W-1:0] step_next;

   // Ops that finish in the accept cycle; mul only lands here with B=0.
   always_comb begin
      imm_res    = '0;
      imm_borrow = 1'b0;
      imm_err    = 1'b0;
      case (bus.in_op)
         OP_ADD: imm_res = {{(W-1){1'b0}}, {1'b0, bus.in_a} + {1'b0, bus.in_b}};
         OP_SUB: begin
            imm_res    = {{W{1'b0}}, bus.in_a} - {{W{1'b0}}, bus.in_b};
            imm_borrow = (bus.in_a < bus.in_b);
         end
         OP_MUL: imm_res = '0;
         OP_DIV: begin
            imm_res = '1;
            imm_err = 1'b1;
         end
         OP_AND:  imm_res = {{W{1'b0}}, bus.in_a & bus.in_b};
         OP_OR:   imm_res = {{W{1'b0}}, bus.in_a | bus.in_b};
         OP_XOR:  imm_res = {{W{1'b0}}, bus.in_a ^ bus.in_b};
         default: imm_err = 1'b1;
      endcase
   end

   // work_q is {high, low}: mul keeps {partial product, remaining multiplier},
   // div keeps {partial remainder, dividend shifting into quotient}.
   always_comb begin
      mul_sum   = {1'b0, work_q[2*W-1:W]} + (work_q[0] ? {1'b0, b_q} : '0);
      mul_next  = {mul_sum, work_q[W-1:1]};
      div_shift = {work_q[2*W-1:W], work_q[W-1]};
      div_ge    = (div_shift >= {1'b0, b_q});
      div_rem   = div_ge ? W'(div_shift - {1'b0, b_q}) : div_shift[W-1:0];
      div_next  = {div_rem, work_q[W-2:0], div_ge};
      step_next = div_q ? div_next : mul_next;
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      work_d   = work_q;
      b_d      = b_q;
      div_d    = div_q;
      res_d    = res_q;
      zero_d   = zero_q;
      borrow_d = borrow_q;
      err_d    = err_q;
      case (state_q)
         S_IDLE: begin
            if (bus.in_valid) begin
               if ((bus.in_op == OP_MUL || bus.in_op == OP_DIV) && bus.in_b != '0) begin
                  state_d = S_BUSY;
                  cnt_d   = '0;
                  work_d  = {{W{1'b0}}, bus.in_a};
                  b_d     = bus.in_b;
                  div_d   = (bus.in_op == OP_DIV);
               end else begin
                  state_d  = S_DONE;
                  res_d    = imm_res;
                  zero_d   = (imm_res == '0);
                  borrow_d = imm_borrow;
                  err_d    = imm_err;
               end
            end
         end
         S_BUSY: begin
            work_d = step_next;
            if (cnt_q == CW'(W-1)) begin
               state_d  = S_DONE;
               res_d    = step_next;
               zero_d   = (step_next == '0);
               borrow_d = 1'b0;
               err_d    = 1'b0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DONE: begin
            if (bus.out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         work_q   <= '0;
         b_q      <= '0;
         div_q    <= 1'b0;
         res_q    <= '0;
         zero_q   <= 1'b0;
         borrow_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         work_q   <= work_d;
         b_q      <= b_d;
         div_q    <= div_d;
         res_q    <= res_d;
         zero_q   <= zero_d;
         borrow_q <= borrow_d;
         err_q    <= err_d;
      end
   end

   assign bus.in_ready   = (state_q == S_IDLE);
   assign bus.out_valid  = (state_q == S_DONE);
   assign bus.out_result = res_q;
   assign bus.out_zero   = zero_q;
   assign bus.out_borrow = borrow_q;
   assign bus.out_err    = err_q;
   assign state_o        = state_q;
endmodule

// File: tb/tb_tt_alu_seq.sv
// Bench for tt_alu_seq: a W=4 and a W=8 instance driven from shared operand signals,
// checked against an arithmetic reference model through an expected-result queue.
module tb_tt_alu_seq;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   tt_alu_seq_if #(.W(4)) bus4 ();
   tt_alu_seq_if #(.W(8)) bus8 ();
   logic [1:0] st4, st8;

   tt_alu_seq #(.W(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4), .state_o(st4));
   tt_alu_seq #(.W(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8), .state_o(st8));

   logic [15:0] drv_a = '0, drv_b = '0;
   logic [2:0]  drv_op = '0;
   logic        v4 = 1'b0, v8 = 1'b0, r4 = 1'b0, r8 = 1'b0;
   bit          sel = 1'b0;

   assign bus4.in_valid  = v4;
   assign bus4.in_a      = drv_a[3:0];
   assign bus4.in_b      = drv_b[3:0];
   assign bus4.in_op     = drv_op;
   assign bus4.out_ready = r4;
   assign bus8.in_valid  = v8;
   assign bus8.in_a      = drv_a[7:0];
   assign bus8.in_b      = drv_b[7:0];
   assign bus8.in_op     = drv_op;
   assign bus8.out_ready = r8;

   logic        obs_in_ready, obs_out_valid, obs_zero, obs_borrow, obs_err;
   logic [31:0] obs_result;
   always_comb begin
      obs_in_ready  = sel ? bus8.in_ready   : bus4.in_ready;
      obs_out_valid = sel ? bus8.out_valid  : bus4.out_valid;
      obs_zero      = sel ? bus8.out_zero   : bus4.out_zero;
      obs_borrow    = sel ? bus8.out_borrow : bus4.out_borrow;
      obs_err       = sel ? bus8.out_err    : bus4.out_err;
      obs_result    = sel ? 32'(bus8.out_result) : 32'(bus4.out_result);
   end

   int n_tests = 0;
   int n_fail  = 0;
   logic [34:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference: result rules written as plain integer arithmetic modulo 2^(2w).
   function automatic logic [34:0] ref_model(input int w, input logic [2:0] op,
                                             input logic [15:0] a, input logic [15:0] b);
      longint mask, la, lb, r;
      logic   er, bo;
      mask = (64'sd1 <<< (2 * w)) - 1;
      la = longint'(a);
      lb = longint'(b);
      er = 1'b0;
      bo = 1'b0;
      case (op)
         3'd0: r = la + lb;
         3'd1: begin r = la - lb; bo = (la < lb); end
         3'd2: r = la * lb;
         3'd3: begin
            if (lb == 0) begin r = mask; er = 1'b1; end
            else r = ((la % lb) <<< w) + (la / lb);
         end
         3'd4: r = la & lb;
         3'd5: r = la | lb;
         3'd6: r = la ^ lb;
         default: begin r = 0; er = 1'b1; end
      endcase
      r = r & mask;
      return {er, bo, (r == 0), r[31:0]};
   endfunction

   task automatic set_valid(input bit s, input logic v);
      if (s) v8 = v; else v4 = v;
   endtask

   task automatic set_ready(input bit s, input logic v);
      if (s) r8 = v; else r4 = v;
   endtask

   // Issue one op, measure cycles from the accept cycle to the first out_valid cycle,
   // compare against the scoreboard, optionally stall, then retire the result.
   task automatic run_op(input bit s, input logic [2:0] op, input logic [15:0] a,
                         input logic [15:0] b, input int stall, input bit early_ready);
      int          w, lat, exp_lat, guard;
      logic [34:0] e;
      w = s ? 8 : 4;
      sel = s;
      guard = 0;
      @(negedge clk);
      while (!obs_in_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      check("in_ready_before_op", 32'(obs_in_ready), 32'd1);
      drv_a  = a;
      drv_b  = b;
      drv_op = op;
      set_valid(s, 1'b1);
      if (early_ready) set_ready(s, 1'b1);
      exp_q.push_back(ref_model(w, op, a & 16'((1 << w) - 1), b & 16'((1 << w) - 1)));
      exp_lat = ((op == 3'd2 || op == 3'd3) && (b & 16'((1 << w) - 1)) != 0) ? w + 1 : 1;
      lat = 0;
      do begin
         @(posedge clk);
         #1;
         if (lat == 0) set_valid(s, 1'b0);
         lat++;
         if (!obs_out_valid) begin
            drv_a  = 16'($urandom);
            drv_b  = 16'($urandom);
            drv_op = 3'($urandom_range(0, 7));
         end
      end while (!obs_out_valid && lat < 40);
      check("latency", 32'(lat), 32'(exp_lat));
      e = exp_q.pop_front();
      check("result", obs_result, e[31:0]);
      check("zero", 32'(obs_zero), 32'(e[32]));
      check("borrow", 32'(obs_borrow), 32'(e[33]));
      check("err", 32'(obs_err), 32'(e[34]));
      check("in_ready_in_done", 32'(obs_in_ready), 32'd0);
      if (!early_ready) begin
         for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            #1;
            drv_a = 16'($urandom);
            drv_b = 16'($urandom);
            check("stall_valid", 32'(obs_out_valid), 32'd1);
            check("stall_in_ready", 32'(obs_in_ready), 32'd0);
            check("stall_result", obs_result, e[31:0]);
            check("stall_flags", {29'd0, obs_err, obs_borrow, obs_zero}, {29'd0, e[34:32]});
         end
         @(negedge clk);
         set_ready(s, 1'b1);
      end
      @(posedge clk);
      #1;
      check("idle_after_ack_valid", 32'(obs_out_valid), 32'd0);
      check("idle_after_ack_ready", 32'(obs_in_ready), 32'd1);
      set_ready(s, 1'b0);
   endtask

   task automatic check_reset_values(input bit s, input string tag);
      sel = s;
      #1;
      check({tag, "_in_ready"}, 32'(obs_in_ready), 32'd1);
      check({tag, "_out_valid"}, 32'(obs_out_valid), 32'd0);
      check({tag, "_result"}, obs_result, 32'd0);
      check({tag, "_flags"}, {29'd0, obs_err, obs_borrow, obs_zero}, 32'd0);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check_reset_values(1'b0, "rst4");
      check_reset_values(1'b1, "rst8");
      rst_n = 1'b1;

      run_op(1'b0, 3'd0, 16'd15, 16'd15, 0, 1'b0);
      run_op(1'b0, 3'd1, 16'd3, 16'd5, 1, 1'b0);
      run_op(1'b0, 3'd1, 16'd5, 16'd5, 0, 1'b0);
      run_op(1'b0, 3'd2, 16'd15, 16'd13, 10, 1'b0);
      run_op(1'b1, 3'd2, 16'd255, 16'd255, 0, 1'b0);
      run_op(1'b0, 3'd3, 16'd14, 16'd4, 0, 1'b0);
      run_op(1'b0, 3'd3, 16'd9, 16'd0, 0, 1'b0);
      run_op(1'b0, 3'd7, 16'd6, 16'd3, 0, 1'b0);
      run_op(1'b0, 3'd2, 16'd7, 16'd0, 0, 1'b1);
      run_op(1'b1, 3'd3, 16'd200, 16'd7, 0, 1'b1);

      // Abort a W=4 divide in its second BUSY cycle.
      run_op(1'b0, 3'd0, 16'd9, 16'd4, 0, 1'b0);
      sel = 1'b0;
      @(negedge clk);
      drv_a  = 16'd14;
      drv_b  = 16'd4;
      drv_op = 3'd3;
      v4 = 1'b1;
      @(posedge clk);
      #1 v4 = 1'b0;
      @(posedge clk);
      #3 rst_n = 1'b0;
      check_reset_values(1'b0, "midop_rst");
      @(negedge clk);
      rst_n = 1'b1;
      run_op(1'b0, 3'd0, 16'd1, 16'd1, 0, 1'b0);

      for (int i = 0; i < 150; i++)
         run_op(1'b0, 3'($urandom_range(0, 7)), 16'($urandom_range(0, 15)),
                ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(0, 15)),
                $urandom_range(0, 2), 1'($urandom_range(0, 1)));
      for (int i = 0; i < 60; i++)
         run_op(1'b1, 3'($urandom_range(0, 7)), 16'($urandom_range(0, 255)),
                ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(0, 255)),
                $urandom_range(0, 2), 1'($urandom_range(0, 1)));

      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
